fifo_reader: RTL and testbench
==============================

# fifo_reader

Drain-side controller for the 8-bit, 8-deep byte FIFO. On a `start` pulse it pops exactly `BURST_LEN` entries and presents them downstream (e.g. to a MAC lane) as a valid/ready stream with a last marker. It absorbs the FIFO's one-cycle registered read latency with a 2-entry output buffer, so downstream backpressure never loses data. It sits between each FIFO's read port and its consumer.

## Interface
- `DATA_WIDTH`, 8, FIFO entry / stream width
- `BURST_LEN`, 8, entries popped per `start`; legal range 1..255
- `clk`  in  1  clock
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  one-cycle pulse; begins a burst; sampled only in IDLE
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_rden`  out  1  FIFO read enable
- `fifo_rdata`  in  DATA_WIDTH  FIFO registered read data; valid the cycle after an accepted `fifo_rden`
- `m_valid`  out  1  stream data valid
- `m_ready`  in  1  downstream accept
- `m_data`  out  DATA_WIDTH  stream data
- `m_last`  out  1  high with the BURST_LEN-th beat
- `busy`  out  1  high in RUN and FLUSH
- `done`  out  1  one-cycle pulse after the last beat is accepted

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: on `start`, go to RUN and clear `issue_cnt` and `beat_cnt`. `start` is ignored in every other state.
- RUN: assert `fifo_rden` when all of the following hold:
  - `issue_cnt < BURST_LEN`
  - `!fifo_empty`
  - `occ + inflight - pop < 2`, where `occ` is the buffer count (0..2), `inflight` is `fifo_rden` registered from the previous cycle, and `pop = m_valid & m_ready`.
- The `pop` term makes `fifo_rden` combinationally dependent on `m_ready`. This is intentional and required for 1 beat/cycle throughput.
- Each issued read increments `issue_cnt`. When `issue_cnt` reaches `BURST_LEN`, go to FLUSH.
- Capture: when `inflight` is high, `fifo_rdata` is written into the buffer tail.
- Output:
  - `m_valid = (occ != 0)`; `m_data` is the buffer head.
  - `m_last` is high when `beat_cnt == BURST_LEN-1`.
  - Each pop increments `beat_cnt`.
- A capture and a pop in the same cycle leave `occ` unchanged.
- FLUSH: when the last beat pops, go to DONE.
- DONE: `done = 1` for one cycle, then go to IDLE.
- `fifo_rden` is never asserted while `fifo_empty` is high, and never when the buffer plus in-flight read would exceed 2.
- Reset mid-burst: state returns to IDLE, buffer and counters clear, and any in-flight read data is discarded. The FIFO pointer has already advanced, so that entry is lost. This is accepted behaviour.

## Timing
- Reset values: `fifo_rden=0`, `m_valid=0`, `m_data=0`, `m_last=0`, `busy=0`, `done=0`; all internal counters 0; state IDLE.
- Sequence with a non-empty FIFO and `m_ready=1`:
  - cycle 0: `start` high.
  - cycle 1: RUN, `fifo_rden=1`.
  - cycle 2: `fifo_rdata` valid and captured.
  - cycle 3: `m_valid=1` (first data 2 cycles after first `fifo_rden`).
- Throughput: 1 beat/cycle while the FIFO is non-empty and `m_ready` is held high.
- The last beat is accepted in cycle N. Then DONE (`done=1`) is in cycle N+1 and IDLE in cycle N+2. `start` in cycle N+2 is honoured.
- `m_data`/`m_last` hold stable while `m_valid & !m_ready`.

## Configuration
- `FIFO_READER_STALL_CNT_EN` defined: adds output `stall_cnt [15:0]`.
  - Increments each cycle in RUN with `fifo_empty=1` and `issue_cnt < BURST_LEN`.
  - Saturates at 0xFFFF.
  - Cleared on `rst` and on accepted `start`.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- `fifo_reader_pkg` contains the state enum (IDLE, RUN, FLUSH, DONE), the buffer depth constant `OBUF_DEPTH=2`, and the stall counter width constant `STALL_CNT_W=16`.
- Sub-module `fifo_reader_obuf`: 2-entry buffer with push/pop/occ and head output, parameterised by `DATA_WIDTH`.
- FSM, counters and issue logic live in `fifo_reader`.

## Test plan
- FIFO preloaded 0x10..0x17, `m_ready=1`, `start` -> `fifo_rden` for 8 consecutive cycles; `m_data` 0x10..0x17 on 8 consecutive cycles starting 2 cycles after the first `fifo_rden`; `m_last` with 0x17; `done` 1 cycle later.
- Same preload, `m_ready` toggling 1/0 each cycle -> all 8 bytes delivered in order; `occ + inflight` never exceeds 2; `m_data` stable while stalled.
- FIFO empty at `start`, then one byte pushed every 4 cycles (0xA0..0xA7) -> `fifo_rden` only when non-empty; order preserved. With the macro defined, `stall_cnt` equals the counted empty-RUN cycles.
- `start` re-pulsed during RUN with 16 bytes in the FIFO -> ignored; exactly 8 beats and one `done`. A second `start` after `done` pops the next 8 bytes.
- `rst` asserted after the 3rd accepted beat -> next cycle all outputs 0, state IDLE. A new `start` delivers the next unread FIFO entries, with the in-flight entry lost.
- `BURST_LEN=1`, FIFO holds 0x5A -> single beat 0x5A with `m_last=1`; `done` in the following cycle.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared types and constants for the FIFO drain controller.
// Optional feature macro: FIFO_READER_STALL_CNT_EN (adds the stall counter).
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Output buffer depth; two entries cover the one-cycle FIFO read latency.
  localparam int OBUF_DEPTH = 2;
  localparam int OCC_W = 2;

  localparam int STALL_CNT_W = 16;

  // Saturating increment for the stall counter (holds at all-ones).
  function automatic logic [STALL_CNT_W-1:0] stall_sat_inc(input logic [STALL_CNT_W-1:0] v);
    if (v == {STALL_CNT_W{1'b1}}) begin
      stall_sat_inc = v;
    end else begin
      stall_sat_inc = v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// fifo_reader_if: FIFO read port plus downstream valid/ready stream.
// master = the reader (drives fifo_rden and the stream), slave = FIFO/consumer side.
interface fifo_reader_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  fifo_empty;
  logic                  fifo_rden;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  fifo_empty, fifo_rdata, m_ready,
    output fifo_rden, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_rdata, m_ready,
    input  fifo_rden, m_valid, m_data, m_last
  );

endinterface

// File: rtl/fifo_reader_obuf.sv
// fifo_reader_obuf: 2-entry circular output buffer. Push and pop in the same
// cycle keep occupancy unchanged; a push while full is only taken with a pop.
module fifo_reader_obuf
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OCC_W-1:0]      occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem_q [OBUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [OBUF_DEPTH];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  pop_ok_s;
  logic                  push_ok_s;

  assign pop_ok_s  = pop && (occ_q != 2'd0);
  assign push_ok_s = push && ((occ_q != 2'd2) || pop_ok_s);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Buffer registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pops BURST_LEN entries from a registered-read FIFO per start
// pulse and presents them as a valid/ready stream with a last marker.
// Optional feature macro: FIFO_READER_STALL_CNT_EN (adds stall_cnt output).
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  fifo_reader_if.master    bus,
  output logic             busy,
  output logic             done
`ifdef FIFO_READER_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [7:0] BURST_LEN_C = 8'(BURST_LEN);
  localparam logic [7:0] LAST_IDX_C  = 8'(BURST_LEN - 1);

  state_e                state_q, state_d;
  logic [7:0]            issue_cnt_q, issue_cnt_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [OCC_W-1:0]      occ_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic                  valid_s;
  logic                  pop_s;
  logic                  rden_s;
  logic [7:0]            issue_next_s;

  assign valid_s      = (occ_s != 2'd0);
  assign pop_s        = valid_s && bus.m_ready;
  assign issue_next_s = issue_cnt_q + {7'd0, rden_s};

  fifo_reader_obuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data(bus.fifo_rdata),
    .pop      (pop_s),
    .occ      (occ_s),
    .head     (head_s)
  );

  // Read issue: the pop term lets a read go out in the same cycle a slot frees,
  // which is what sustains one beat per cycle. Reads are held off during reset
  // so the reset cycle itself does not advance the FIFO.
  always_comb begin
    rden_s = 1'b0;
    if (!rst && (state_q == ST_RUN) && (issue_cnt_q < BURST_LEN_C) && !bus.fifo_empty &&
        (({1'b0, occ_s} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s}))) begin
      rden_s = 1'b1;
    end else begin
      rden_s = 1'b0;
    end
  end

  // FSM next state, issue/beat counters and in-flight tracking.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q + {7'd0, pop_s};
    inflight_d  = rden_s;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          issue_cnt_d = 8'd0;
          beat_cnt_d  = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        issue_cnt_d = issue_next_s;
        if (issue_next_s == BURST_LEN_C) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (pop_s && (beat_cnt_q == LAST_IDX_C)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state registers; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= 8'd0;
      beat_cnt_q  <= 8'd0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      inflight_q  <= inflight_d;
    end
  end

`ifdef FIFO_READER_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Count RUN cycles where reads are still owed but the FIFO is empty.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_IDLE) && start) begin
      stall_cnt_d = {STALL_CNT_W{1'b0}};
    end else if ((state_q == ST_RUN) && bus.fifo_empty && (issue_cnt_q < BURST_LEN_C)) begin
      stall_cnt_d = stall_sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= {STALL_CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign bus.fifo_rden = rden_s;
  assign bus.m_valid   = valid_s;
  assign bus.m_data    = head_s;
  assign bus.m_last    = valid_s && (beat_cnt_q == LAST_IDX_C);
  assign busy          = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed bench for fifo_reader with a behavioural FIFO model.
// Optional feature macro: FIFO_READER_STALL_CNT_EN (stall counter checks).
module tb_fifo_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, busy, done;
  logic start1, busy1, done1;

  fifo_reader_if #(.DATA_WIDTH(8)) bus ();
  fifo_reader_if #(.DATA_WIDTH(8)) bus1 ();

`ifdef FIFO_READER_STALL_CNT_EN
  logic [15:0] stall_cnt, stall_cnt1;
`endif

  fifo_reader #(.DATA_WIDTH(8), .BURST_LEN(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy), .done(done)
`ifdef FIFO_READER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  fifo_reader #(.DATA_WIDTH(8), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bus(bus1), .busy(busy1), .done(done1)
`ifdef FIFO_READER_STALL_CNT_EN
    , .stall_cnt(stall_cnt1)
`endif
  );

  // FIFO model for the main DUT: registered read data, one cycle after rden.
  logic [7:0] fmem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       push_en;
  logic [7:0] push_data;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  // FIFO model push/pop.
  always @(posedge clk) begin
    if (push_en) begin
      fmem[wr_ptr] <= push_data;
      wr_ptr       <= wr_ptr + 1;
    end
    if (bus.fifo_rden) begin
      bus.fifo_rdata <= fmem[rd_ptr];
      rd_ptr         <= rd_ptr + 1;
    end
  end

  // Single-entry FIFO model for the BURST_LEN=1 instance, holding 0x5A.
  logic have1 = 1'b0;
  logic load1;
  assign bus1.fifo_empty = !have1;

  // One-byte FIFO model.
  always @(posedge clk) begin
    if (load1) begin
      have1 <= 1'b1;
    end else if (bus1.fifo_rden) begin
      bus1.fifo_rdata <= 8'h5A;
      have1           <= 1'b0;
    end
  end

  int cyc = 0;
  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor records (only written by the stimulus thread).
  int         rden_cyc[$];
  logic [7:0] beat_data[$];
  logic       beat_last[$];
  int         beat_cyc[$];
  int         done_cyc[$];
  int         issued, popped, max_out, stall_model;
  int         rden_empty_err = 0;
  int         stab_err = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic clear_rec();
    rden_cyc.delete(); beat_data.delete(); beat_last.delete();
    beat_cyc.delete(); done_cyc.delete();
    issued = 0; popped = 0; max_out = 0; stall_model = 0;
  endtask

  task automatic sample();
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (busy && bus.fifo_empty && issued < 8) stall_model++;
      if (bus.fifo_rden && bus.fifo_empty) rden_empty_err++;
      if (issued - popped > max_out) max_out = issued - popped;
      if (prev_hold && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last))
        stab_err++;
      prev_hold = bus.m_valid && !bus.m_ready;
      prev_data = bus.m_data;
      prev_last = bus.m_last;
      if (bus.fifo_rden) begin
        rden_cyc.push_back(cyc);
        issued++;
      end
      if (bus.m_valid && bus.m_ready) begin
        beat_data.push_back(bus.m_data);
        beat_last.push_back(bus.m_last);
        beat_cyc.push_back(cyc);
        popped++;
      end
      if (done) done_cyc.push_back(cyc);
    end
  endtask

  // Sample on the falling edge, then return 1 time unit after the next rising edge.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      push_en   = 1'b1;
      push_data = base + 8'(i);
      tick();
    end
    push_en = 1'b0;
  endtask

  task automatic start_burst(output int s);
    clear_rec();
    s     = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input logic toggle);
    int k = 0;
    while (done_cyc.size() < 1 && k < budget) begin
      if (toggle) bus.m_ready = !bus.m_ready;
      tick();
      k++;
    end
    bus.m_ready = 1'b1;
    chk({tag, "_done_seen"}, 32'(done_cyc.size() >= 1), 32'd1);
    repeat (3) tick();
    chk({tag, "_done_count"}, 32'(done_cyc.size()), 32'd1);
  endtask

  task automatic chk_beats(input string tag, input logic [7:0] base);
    int nlast = 0;
    chk({tag, "_beats"}, 32'(beat_data.size()), 32'd8);
    for (int i = 0; i < beat_data.size() && i < 8; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(beat_data[i]), 32'(base + 8'(i)));
      if (beat_last[i]) nlast++;
    end
    chk({tag, "_last_count"}, 32'(nlast), 32'd1);
    if (beat_last.size() == 8) chk({tag, "_last_pos"}, 32'(beat_last[7]), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, "_rden"},  32'(bus.fifo_rden), 32'd0);
    chk({tag, "_valid"}, 32'(bus.m_valid),   32'd0);
    chk({tag, "_data"},  32'(bus.m_data),    32'd0);
    chk({tag, "_last"},  32'(bus.m_last),    32'd0);
    chk({tag, "_busy"},  32'(busy),          32'd0);
    chk({tag, "_done"},  32'(done),          32'd0);
    @(posedge clk);
    #1;
  endtask

  int s;

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; load1 = 1'b0;
    push_en = 1'b0; push_data = 8'h00;
    bus.m_ready = 1'b1; bus1.m_ready = 1'b1;
    @(posedge clk); #1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk_idle("reset");
`ifdef FIFO_READER_STALL_CNT_EN
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // Test 1: full-rate burst 0x10..0x17
    preload(8'h10, 8);
    start_burst(s);
    wait_done("t1", 40, 1'b0);
    chk_beats("t1", 8'h10);
    chk("t1_rden_count", 32'(rden_cyc.size()), 32'd8);
    if (rden_cyc.size() == 8) begin
      chk("t1_rden_first", 32'(rden_cyc[0]), 32'(s + 1));
      chk("t1_rden_last",  32'(rden_cyc[7]), 32'(s + 8));
    end
    if (beat_cyc.size() == 8) begin
      chk("t1_beat_first", 32'(beat_cyc[0]), 32'(s + 3));
      chk("t1_beat_last",  32'(beat_cyc[7]), 32'(s + 10));
    end
    if (done_cyc.size() >= 1) chk("t1_done_cyc", 32'(done_cyc[0]), 32'(s + 11));
    chk("t1_busy_after", 32'(busy), 32'd0);

    // Test 2: m_ready toggling
    preload(8'h10, 8);
    start_burst(s);
    wait_done("t2", 60, 1'b1);
    chk_beats("t2", 8'h10);
    chk("t2_stable", 32'(stab_err), 32'd0);
    chk("t2_outstanding_le2", 32'(max_out <= 2), 32'd1);

    // Test 3: empty FIFO at start, one byte every 4 cycles
    start_burst(s);
    begin
      int k = 0;
      int pushed = 0;
      while (done_cyc.size() < 1 && k < 80) begin
        if ((k % 4) == 0 && pushed < 8) begin
          push_en   = 1'b1;
          push_data = 8'hA0 + 8'(pushed);
          pushed++;
        end else begin
          push_en = 1'b0;
        end
        tick();
        k++;
      end
      push_en = 1'b0;
      chk("t3_done_seen", 32'(done_cyc.size() >= 1), 32'd1);
    end
    repeat (3) tick();
    chk("t3_done_count", 32'(done_cyc.size()), 32'd1);
    chk_beats("t3", 8'hA0);
    chk("t3_no_rden_when_empty", 32'(rden_empty_err), 32'd0);
`ifdef FIFO_READER_STALL_CNT_EN
    chk("t3_stall_cnt", 32'(stall_cnt), 32'(stall_model));
    chk("t3_stall_nonzero", 32'(stall_model > 0), 32'd1);
`endif

    // Test 4: start re-pulsed during RUN is ignored
    preload(8'h30, 16);
    start_burst(s);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4a", 40, 1'b0);
    chk_beats("t4a", 8'h30);
    start_burst(s);
    wait_done("t4b", 40, 1'b0);
    chk_beats("t4b", 8'h38);

    // Test 5: reset after the 3rd accepted beat
    preload(8'h40, 16);
    start_burst(s);
    repeat (5) tick();
    chk("t5_pre_beats", 32'(beat_data.size()), 32'd3);
    if (beat_data.size() == 3) chk("t5_pre_beat3", 32'(beat_data[2]), 32'h42);
    rst = 1'b1;
    bus.m_ready = 1'b0;
    tick();
    rst = 1'b0;
    bus.m_ready = 1'b1;
    chk_idle("t5_post_rst");
    start_burst(s);
    wait_done("t5", 40, 1'b0);
    chk_beats("t5", 8'h45);

    // Test 6: BURST_LEN=1 instance, single byte 0x5A
    load1 = 1'b1;
    @(posedge clk); #1;
    load1  = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    chk("t6_rden", 32'(bus1.fifo_rden), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_rden_once", 32'(bus1.fifo_rden), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_valid", 32'(bus1.m_valid), 32'd1);
    chk("t6_data",  32'(bus1.m_data),  32'h5A);
    chk("t6_last",  32'(bus1.m_last),  32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_done", 32'(done1), 32'd1);
    chk("t6_valid_after", 32'(bus1.m_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_done_pulse", 32'(done1), 32'd0);
    chk("t6_busy_idle",  32'(busy1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
